// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI target that emulates a 23LC1024-style serial SRAM
// with 16-bit data words held in on-chip memory. SPI pins are oversampled
// in the clk domain (clk >= 4x sck_ram).
// Optional: define SPI_RAM_MODE_REG_EN to add the 8-bit mode register
// (WRMR 8'h01 / RDMR 8'h05, byte mode when mode[7:6]==2'b00).
module spi_ram_responder #(
   parameter int         MEM_AW    = 10,
   parameter logic [7:0] CMD_WRITE = 8'h02,
   parameter logic [7:0] CMD_READ  = 8'h03
) (
   input  logic clk,
   input  logic nrst,
   input  logic sck_ram,
   input  logic css_ram,
   input  logic sdi_ram,
   output logic sdo_ram,
   output logic busy,
   output logic wr_strobe
);

   localparam int DEPTH = 1 << MEM_AW;
   localparam logic [MEM_AW-1:0] IDX_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADDR_W, S_ADDR_R, S_DATA_W, S_DATA_R, S_IGNORE,
      S_MODE_W, S_MODE_R
   } state_t;

   state_t state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [14:0]       sh_q, sh_d;
   logic [MEM_AW-1:0] idx_q, idx_d;
   logic [15:0]       tx_q, tx_d;
   logic              sdo_q, sdo_d;
   logic              busy_q, busy_d;
   logic              wr_strobe_q, wr_strobe_d;

   logic [15:0]       mem [DEPTH];
   logic              mem_we;
   logic [MEM_AW-1:0] idx_inc, rd_idx;
   logic [15:0]       rd_word, sh_in;
   logic              byte_mode;

   // Synchronizers: [0] first stage, [1] synced, [2] previous synced value.
   // Deliberately not reset so a reset mid-frame cannot fake a css edge.
   logic [2:0] sck_s_q, css_s_q;
   logic [1:0] sdi_s_q;
   logic       sck_rise, sck_fall, css_fall, css_rise;

   // Two-flop synchronizers plus one history flop for edge detection
   always_ff @(posedge clk) begin
      sck_s_q <= {sck_s_q[1:0], sck_ram};
      css_s_q <= {css_s_q[1:0], css_ram};
      sdi_s_q <= {sdi_s_q[0], sdi_ram};
   end

   assign sck_rise = sck_s_q[1] & ~sck_s_q[2];
   assign sck_fall = ~sck_s_q[1] & sck_s_q[2];
   assign css_fall = ~css_s_q[1] & css_s_q[2];
   assign css_rise = css_s_q[1] & ~css_s_q[2];

   // 16-bit window of the incoming stream: holds the opcode, the low
   // address bits at the end of the address phase, or the data word.
   assign sh_in   = {sh_q, sdi_s_q[1]};
   assign idx_inc = idx_q + IDX_ONE;
   // Read port: first word comes from the just-completed address,
   // later burst words from the next sequential index.
   assign rd_idx  = (state_q == S_DATA_R) ? idx_inc : sh_in[MEM_AW:1];
   assign rd_word = mem[rd_idx];

`ifdef SPI_RAM_MODE_REG_EN
   logic [7:0] mode_q, mode_d;
   assign byte_mode = (mode_q[7:6] == 2'b00);
`else
   assign byte_mode = 1'b0;
`endif

   // Next-state and datapath control
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      idx_d       = idx_q;
      tx_d        = tx_q;
      sdo_d       = 1'b0;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      mem_we      = 1'b0;
`ifdef SPI_RAM_MODE_REG_EN
      mode_d      = mode_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (css_fall) begin
               state_d = S_CMD;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_CMD: begin
            if (sck_rise) begin
               sh_d  = sh_in[14:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d = '0;
                  if (sh_in[7:0] == CMD_WRITE)     state_d = S_ADDR_W;
                  else if (sh_in[7:0] == CMD_READ) state_d = S_ADDR_R;
`ifdef SPI_RAM_MODE_REG_EN
                  else if (sh_in[7:0] == 8'h01)    state_d = S_MODE_W;
                  else if (sh_in[7:0] == 8'h05)    state_d = S_MODE_R;
`endif
                  else                             state_d = S_IGNORE;
               end
            end
         end
         S_ADDR_W, S_ADDR_R: begin
            if (sck_rise) begin
               sh_d  = sh_in[14:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd23) begin
                  cnt_d = '0;
                  idx_d = sh_in[MEM_AW:1];
                  if (state_q == S_ADDR_W) begin
                     state_d = S_DATA_W;
                  end else begin
                     tx_d    = rd_word;
                     state_d = S_DATA_R;
                  end
               end
            end
         end
         S_DATA_W: begin
            if (sck_rise) begin
               sh_d  = sh_in[14:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd15) begin
                  mem_we      = 1'b1;
                  wr_strobe_d = 1'b1;
                  idx_d       = idx_inc;
                  cnt_d       = '0;
                  if (byte_mode) state_d = S_IGNORE;
               end
            end
         end
         S_DATA_R: begin
            sdo_d = sdo_q;
            if (sck_fall) begin
               sdo_d = tx_q[15];
               if (cnt_q == 5'd15) begin
                  // Reload on the last bit's fall so the next word's MSB
                  // follows on the very next fall with no gap.
                  cnt_d = '0;
                  if (byte_mode) begin
                     tx_d = '0;
                  end else begin
                     idx_d = idx_inc;
                     tx_d  = rd_word;
                  end
               end else begin
                  tx_d  = {tx_q[14:0], 1'b0};
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
`ifdef SPI_RAM_MODE_REG_EN
         S_MODE_W: begin
            if (sck_rise) begin
               sh_d  = sh_in[14:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  mode_d  = sh_in[7:0];
                  state_d = S_IGNORE;
               end
            end
         end
         S_MODE_R: begin
            sdo_d = sdo_q;
            if (sck_fall) begin
               sdo_d = mode_q[3'd7 - cnt_q[2:0]];
               cnt_d = cnt_q + 5'd1;
            end
         end
`endif
         default: ;
      endcase
      // Deselect ends any frame; partial words/addresses are dropped
      if (css_rise && state_q != S_IDLE) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         sdo_d   = 1'b0;
         cnt_d   = '0;
      end
   end

   // Control/state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         idx_q       <= '0;
         tx_q        <= '0;
         sdo_q       <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
`ifdef SPI_RAM_MODE_REG_EN
         mode_q      <= 8'h40;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         idx_q       <= idx_d;
         tx_q        <= tx_d;
         sdo_q       <= sdo_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
`ifdef SPI_RAM_MODE_REG_EN
         mode_q      <= mode_d;
`endif
      end
   end

   // Backing memory; contents survive reset
   always_ff @(posedge clk) begin
      if (nrst && mem_we) mem[idx_q] <= sh_in;
   end

   assign sdo_ram   = sdo_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Testbench for spi_ram_responder: bit-banged SPI initiator, word-level
// memory model, directed and randomized write/read frames.
module tb_spi_ram_responder;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;
   localparam int H     = 6;          // clk cycles per sck half period

   logic clk = 1'b0;
   logic nrst = 1'b0, sck = 1'b0, css = 1'b1, sdi = 1'b0;
   logic sdo, busy, wrs;

   int vectors = 0, miscompares = 0, wr_cnt = 0;
   logic [15:0] ref_mem [int];
   logic [15:0] wq [$];
   bit bm = 1'b0;                      // model of byte mode

   always #5 clk = ~clk;

   spi_ram_responder #(.MEM_AW(AW)) dut (
      .clk(clk), .nrst(nrst), .sck_ram(sck), .css_ram(css), .sdi_ram(sdi),
      .sdo_ram(sdo), .busy(busy), .wr_strobe(wrs)
   );

   always @(negedge clk) if (wrs === 1'b1) wr_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One mode-0 bit: drive sdi while sck low, sample sdo just before rise
   task automatic spi_bit(input logic b, output logic r);
      sdi = b;
      clks(H);
      r = sdo;
      sck = 1'b1;
      clks(H);
      sck = 1'b0;
   endtask

   task automatic xfer(input logic [31:0] v, input int n, output logic [31:0] r);
      logic b;
      r = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_bit(v[i], b);
         r = {r[30:0], b};
      end
   endtask

   task automatic frame_start();
      css = 1'b0;
      clks(H);
   endtask

   task automatic frame_end();
      clks(H);
      css = 1'b1;
      clks(4 * H);
   endtask

   function automatic int widx(input logic [23:0] a, input int k);
      return (int'(a >> 1) + k) % DEPTH;
   endfunction

   // Write burst of wq[0..n-1]; model commits every word, or only the
   // first one in byte mode.
   task automatic wr_frame(input string tag, input logic [23:0] a, input int n);
      logic [31:0] r;
      int c0, ncommit;
      c0 = wr_cnt;
      ncommit = bm ? 1 : n;
      frame_start();
      xfer({8'h02, a}, 32, r);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      for (int k = 0; k < n; k++) begin
         xfer(32'(wq[k]), 16, r);
         if (k < ncommit) ref_mem[widx(a, k)] = wq[k];
      end
      frame_end();
      chk({tag, " strobes"}, 32'(wr_cnt - c0), 32'(ncommit));
   endtask

   task automatic rd_frame(input string tag, input logic [23:0] a, input int n);
      logic [31:0] r;
      logic [15:0] exp;
      frame_start();
      xfer({8'h03, a}, 32, r);
      chk({tag, " hdr sdo"}, r, 32'd0);
      for (int k = 0; k < n; k++) begin
         xfer(32'd0, 16, r);
         exp = (bm && k > 0) ? 16'h0 : ref_mem[widx(a, k)];
         chk($sformatf("%s word%0d", tag, k), r, 32'(exp));
      end
      frame_end();
   endtask

   initial begin
      logic [31:0] r;
      logic [23:0] a;
      int n, c0;

      // Reset state
      nrst = 1'b0; css = 1'b1;
      clks(3);
      chk("rst sdo", 32'(sdo), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst wrs", 32'(wrs), 32'd0);
      nrst = 1'b1;
      clks(4);

      // Write then read
      wq = '{16'hABCD};
      wr_frame("wr10", 24'h000010, 1);
      rd_frame("rd10", 24'h000010, 1);

      // Wrap burst at the top of the array
      wq = '{16'h1111, 16'h2222};
      wr_frame("wrwrap", 24'(2 * (DEPTH - 1)), 2);
      rd_frame("rd0", 24'h000000, 1);
      rd_frame("rdwrap", 24'(2 * (DEPTH - 1)), 2);

      // Abort: 9 data bits then deselect
      wq = '{16'h5A5A};
      wr_frame("wr20", 24'h000020, 1);
      c0 = wr_cnt;
      frame_start();
      xfer({8'h02, 24'h000020}, 32, r);
      xfer(32'h1FF, 9, r);
      frame_end();
      chk("abort strobes", 32'(wr_cnt - c0), 32'd0);
      rd_frame("rd20", 24'h000020, 1);

      // Unknown opcode
      c0 = wr_cnt;
      frame_start();
      xfer({8'hFF, 24'($urandom)}, 32, r);
      chk("badop sdo a", r, 32'd0);
      xfer($urandom, 8, r);
      chk("badop sdo b", r, 32'd0);
      frame_end();
      chk("badop strobes", 32'(wr_cnt - c0), 32'd0);
      rd_frame("rd10b", 24'h000010, 1);

      // Reset mid write frame; rest of the frame must be ignored
      c0 = wr_cnt;
      frame_start();
      xfer({8'h02, 24'h000010}, 32, r);
      xfer(32'h12, 8, r);
      nrst = 1'b0;
      clks(2);
      chk("midrst busy", 32'(busy), 32'd0);
      nrst = 1'b1;
      xfer(32'h34, 8, r);
      xfer(32'h5678, 16, r);
      frame_end();
      chk("midrst strobes", 32'(wr_cnt - c0), 32'd0);
      rd_frame("rd10c", 24'h000010, 1);

      // Randomized bursts
      for (int it = 0; it < 6; it++) begin
         a = 24'($urandom);
         n = $urandom_range(1, 3);
         wq.delete();
         for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
         wr_frame($sformatf("rndwr%0d", it), a, n);
         rd_frame($sformatf("rndrd%0d", it), a, n);
      end

`ifdef SPI_RAM_MODE_REG_EN
      // Mode register read after reset repeats every 8 bits
      frame_start();
      xfer(32'h05, 8, r);
      xfer(32'd0, 16, r);
      chk("rdmr", r, 32'h4040);
      frame_end();
      wq = '{16'hC0DE, 16'hBEEF};
      wr_frame("wr100", 24'h000100, 2);
      // Byte mode: one word per frame
      frame_start();
      xfer(32'h0100, 16, r);
      frame_end();
      bm = 1'b1;
      wq = '{16'h1357, 16'h2468};
      wr_frame("bmwr", 24'h000100, 2);
      rd_frame("bmrd", 24'h000100, 2);
      frame_start();
      xfer(32'h0140, 16, r);
      frame_end();
      bm = 1'b0;
      rd_frame("seqrd", 24'h000100, 2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
- Synthesizable SPI SRAM responder: the target end of the RAM SPI link driven by the delay core.
- Emulates a 23LC1024-style serial SRAM with 16-bit data words, backed by on-chip memory.
- Replaces the external SRAM for on-FPGA loopback and self-test.
- Oversamples the SPI pins in the system clock domain; clk must be at least 4x the sck_ram frequency.

Parameters:
- MEM_AW, 10: word-address width of the internal array (2^MEM_AW words of 16 bits).
- CMD_WRITE, 8'h02: write opcode.
- CMD_READ, 8'h03: read opcode.

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous active-low reset.
- sck_ram  in  1  SPI clock from the initiator, mode 0 (idle low).
- css_ram  in  1  chip select from the initiator, active low.
- sdi_ram  in  1  serial data into the responder (initiator MOSI).
- sdo_ram  out  1  serial data out of the responder (initiator MISO).
- busy  out  1  high while a framed transaction is in progress.
- wr_strobe  out  1  one-clk pulse when a word is committed to memory.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (nrst). All state updates on posedge clk.
- Input sync: sck_ram, css_ram and sdi_ram each pass through a 2-flop synchronizer. Edge detect on the synced sck_ram gives sck_rise and sck_fall strobes; edge detect on synced css_ram gives frame start (falling) and frame end (rising).
- Sampling: sdi_ram is sampled on sck_rise. sdo_ram changes only on sck_fall, or on the clk that loads the read word.
- Reset values: sdo_ram=0, busy=0, wr_strobe=0, state=IDLE, bit counter=0. Memory contents are not reset.
- Frame format, MSB first: 8-bit command, then 24-bit byte address, then 16-bit data words. A core transfer is 48 sck.
- Word index into the array = addr[MEM_AW:1]; addr[0] and the upper address bits are ignored.
- IDLE -> CMD on css_ram falling; counter cleared; busy=1.
- CMD: shift 8 bits. On the 8th rising edge: CMD_WRITE -> ADDR_W; CMD_READ -> ADDR_R; any other opcode -> IGNORE.
- ADDR_W / ADDR_R: shift 24 bits.
  - ADDR_W: on the 24th rising edge -> DATA_W.
  - ADDR_R: on the 24th rising edge, read the word at the index into the TX shift register, then -> DATA_R.
  - ADDR_R timing: the MSB is driven on sdo_ram at the following sck_fall, so it is valid before the first data rising edge.
- DATA_W:
  - Shift 16 bits.
  - On the 16th rising edge: write the word to the index, pulse wr_strobe for 1 clk, advance the index by 1 (byte address +2, wrapping modulo 2^MEM_AW words), reset the data counter. Stay in DATA_W (burst).
- DATA_R:
  - On each sck_fall, shift out the next bit.
  - After 16 bits, advance the index with the same wrap and reload the next word so the burst continues seamlessly.
- IGNORE: sdo_ram=0; all sck activity is ignored until css_ram rises.
- css_ram rising in any state -> IDLE next clk; busy=0; sdo_ram=0.
  - A partial write word (fewer than 16 bits) is discarded; memory is unchanged.
  - A partial address is discarded.
- sck edges while css_ram is high are ignored.
- css_ram falling and rising inside a single synced sample pair is not supported (minimum css high time is 2 sck periods).
- nrst low mid-frame: immediate return to reset values on that clk; memory is unchanged. A frame already in progress is ignored until css_ram rises and falls again.
- sdo_ram is 0 whenever not in DATA_R. There is no tristate.

Optional Feature:
- Macro SPI_RAM_MODE_REG_EN.
- Defined: adds an 8-bit mode register, reset value 8'h40 (sequential mode).
  - Opcode 8'h01 (WRMR): the next 8 bits are written to the register.
  - Opcode 8'h05 (RDMR): the register is shifted out MSB first on subsequent sck_fall edges, repeating every 8 bits until css_ram rises.
  - When mode[7:6]==2'b00 (byte mode), data bursts stop after one word; further bits in that frame are ignored (read returns 0, write discards).
- Undefined: opcodes 01/05 fall into IGNORE; behaviour is always sequential.

Test Plan:
- Reset: nrst=0 for 2 clk with css_ram=1 -> sdo_ram=0, busy=0, wr_strobe=0.
- Write then read: frame 02 000010 ABCD, then frame 03 000010 -> a single wr_strobe pulse; read returns 16'hABCD on sdo_ram.
- Wrap burst: write 02 (byte address 2*(2^MEM_AW-1)) with words 1111, 2222 -> read from address 0 returns 2222, and the last word reads 1111.
- Abort: 02 000020 with only 9 data bits, then css_ram high; then read 000020 -> prior contents returned; no wr_strobe pulse.
- Bad opcode: frame 0xFF + 40 bits -> sdo_ram stays 0, no write; the next valid frame works normally.
- SPI_RAM_MODE_REG_EN: RDMR after reset -> 8'h40; WRMR 00, then write 2 words -> only the first is committed (1 wr_strobe).
